// File: rtl/mod_n_counter.sv
// Synchronous modulo-N up/down counter with clamped parallel load, clear and cascade outputs.
// Define MODN_CNT_OVF_STICKY_EN to add the sticky overflow flag output `ovf`.
module mod_n_counter #(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
`ifdef MODN_CNT_OVF_STICKY_EN
  ,
  output logic             ovf
`endif
);

  // MOD_X holds MODULUS in WIDTH+1 bits so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 64'sd1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q;
  logic [WIDTH:0]   inc_w;
  logic [WIDTH:0]   ld_ext;
  logic [WIDTH-1:0] ld_clamp;
  logic             at_top, at_bot, tc_w;

  assign inc_w    = {1'b0, q_q} + (WIDTH+1)'(1);
  assign at_top   = (inc_w == MOD_X);
  assign at_bot   = (q_q == '0);
  assign ld_ext   = {1'b0, ld_val};
  assign ld_clamp = (ld_ext < MOD_X) ? ld_val : LAST;

  // High exactly in the cycle whose edge wraps the count.
  assign tc_w = en & ~rst & ~clr & ~ld & (up ? at_top : at_bot);

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (ld) begin
      q_d = ld_clamp;
    end else if (en) begin
      if (up) begin
        q_d = at_top ? '0 : inc_w[WIDTH-1:0];
      end else begin
        q_d = at_bot ? LAST : (q_q - WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= tc_w;
    end
  end

`ifdef MODN_CNT_OVF_STICKY_EN
  logic ovf_q;

  // Sets the edge after a wrap pulse; only reset or clear release it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ovf_q <= 1'b0;
    end else if (wrap_q) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`endif

  assign q    = q_q;
  assign tc   = tc_w;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench for mod_n_counter: mod-10, full-range mod-16, 1-bit mod-2 and a two-stage cascade.
// Checks ovf as well when MODN_CNT_OVF_STICKY_EN is defined.
module tb_mod_n_counter;

  logic clk;
  int   n_tests;
  int   n_fail;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: WIDTH=4, MODULUS=10 ----------------
  logic       a_rst, a_en, a_up, a_ld, a_clr, a_tc, a_wrap;
  logic [3:0] a_ld_val, a_q;
`ifdef MODN_CNT_OVF_STICKY_EN
  logic       a_ovf;
`endif
  mod_n_counter #(.WIDTH(4), .MODULUS(10)) u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .ld(a_ld), .ld_val(a_ld_val),
    .clr(a_clr), .q(a_q), .tc(a_tc), .wrap(a_wrap)
`ifdef MODN_CNT_OVF_STICKY_EN
    , .ovf(a_ovf)
`endif
  );

  // ---------------- DUT B: WIDTH=4, MODULUS=16 ----------------
  logic       b_en, b_up, b_tc, b_wrap;
  logic [3:0] b_q;
`ifdef MODN_CNT_OVF_STICKY_EN
  logic       b_ovf;
`endif
  mod_n_counter #(.WIDTH(4), .MODULUS(16)) u_b (
    .clk(clk), .rst(a_rst), .en(b_en), .up(b_up), .ld(1'b0), .ld_val(4'd0),
    .clr(1'b0), .q(b_q), .tc(b_tc), .wrap(b_wrap)
`ifdef MODN_CNT_OVF_STICKY_EN
    , .ovf(b_ovf)
`endif
  );

  // ---------------- DUT C: WIDTH=1, MODULUS=2 ----------------
  logic       c_en, c_tc, c_wrap;
  logic [0:0] c_q;
`ifdef MODN_CNT_OVF_STICKY_EN
  logic       c_ovf;
`endif
  mod_n_counter #(.WIDTH(1), .MODULUS(2)) u_c (
    .clk(clk), .rst(a_rst), .en(c_en), .up(1'b1), .ld(1'b0), .ld_val(1'b0),
    .clr(1'b0), .q(c_q), .tc(c_tc), .wrap(c_wrap)
`ifdef MODN_CNT_OVF_STICKY_EN
    , .ovf(c_ovf)
`endif
  );

  // ---------------- Cascade D0 -> D1, both MODULUS=10 ----------------
  logic       d_en, d0_tc, d0_wrap, d1_tc, d1_wrap;
  logic [3:0] d0_q, d1_q;
`ifdef MODN_CNT_OVF_STICKY_EN
  logic       d0_ovf, d1_ovf;
`endif
  mod_n_counter #(.WIDTH(4), .MODULUS(10)) u_d0 (
    .clk(clk), .rst(a_rst), .en(d_en), .up(1'b1), .ld(1'b0), .ld_val(4'd0),
    .clr(1'b0), .q(d0_q), .tc(d0_tc), .wrap(d0_wrap)
`ifdef MODN_CNT_OVF_STICKY_EN
    , .ovf(d0_ovf)
`endif
  );
  mod_n_counter #(.WIDTH(4), .MODULUS(10)) u_d1 (
    .clk(clk), .rst(a_rst), .en(d0_tc), .up(1'b1), .ld(1'b0), .ld_val(4'd0),
    .clr(1'b0), .q(d1_q), .tc(d1_tc), .wrap(d1_wrap)
`ifdef MODN_CNT_OVF_STICKY_EN
    , .ovf(d1_ovf)
`endif
  );

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle away from it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int wrap_cnt;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    a_rst = 1'b1; a_en = 1'b1; a_up = 1'b1; a_ld = 1'b1; a_ld_val = 4'd5; a_clr = 1'b0;
    b_en = 1'b0; b_up = 1'b1; c_en = 1'b0; d_en = 1'b0;

    // Reset over two edges with en and ld asserted.
    step();
    step();
    check_eq("rst_q", a_q, 0);
    check_eq("rst_wrap", a_wrap, 0);
    check_eq("rst_tc", a_tc, 0);
`ifdef MODN_CNT_OVF_STICKY_EN
    check_eq("rst_ovf", a_ovf, 0);
`endif
    check_eq("rst_b_q", b_q, 0);
    check_eq("rst_d1_q", d1_q, 0);

    // Up count 0..9,0.
    a_rst = 1'b0; a_ld = 1'b0; a_en = 1'b1; a_up = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      check_eq("up_tc", a_tc, (i == 9) ? 1 : 0);
      step();
      check_eq("up_q", a_q, (i + 1) % 10);
      check_eq("up_wrap", a_wrap, (i == 9) ? 1 : 0);
`ifdef MODN_CNT_OVF_STICKY_EN
      check_eq("up_ovf", a_ovf, 0);
`endif
    end

    // Down from 0 wraps to 9; wrap stays high as a second back-to-back wrap.
    a_up = 1'b0;
    #1;
    check_eq("dn_tc0", a_tc, 1);
    step();
    check_eq("dn_q9", a_q, 9);
    check_eq("dn_wrap", a_wrap, 1);
`ifdef MODN_CNT_OVF_STICKY_EN
    check_eq("ovf_set", a_ovf, 1);
`endif
    step();
    check_eq("dn_q8", a_q, 8);
    check_eq("dn_wrap_lo", a_wrap, 0);
    step();
    step();
    step();
    check_eq("dn_q5", a_q, 5);
`ifdef MODN_CNT_OVF_STICKY_EN
    check_eq("ovf_hold", a_ovf, 1);
`endif
    a_up = 1'b1;
    step();
    check_eq("flip_q6", a_q, 6);

    // Clear releases everything.
    a_clr = 1'b1;
    #1;
    check_eq("clr_tc", a_tc, 0);
    step();
    a_clr = 1'b0;
    check_eq("clr_q", a_q, 0);
    check_eq("clr_wrap", a_wrap, 0);
`ifdef MODN_CNT_OVF_STICKY_EN
    check_eq("clr_ovf", a_ovf, 0);
`endif

    // Load and priority.
    a_en = 1'b0; a_ld = 1'b1; a_ld_val = 4'd7;
    step();
    check_eq("ld7", a_q, 7);
    a_ld_val = 4'd12;
    step();
    check_eq("ld12_clamp", a_q, 9);
    a_ld_val = 4'd15;
    step();
    check_eq("ld15_clamp", a_q, 9);
    a_ld_val = 4'd3; a_clr = 1'b1;
    step();
    check_eq("ld_clr_q", a_q, 0);
    a_clr = 1'b0; a_ld_val = 4'd9;
    step();
    check_eq("ld9", a_q, 9);
    a_en = 1'b1; a_up = 1'b1; a_ld_val = 4'd4;
    #1;
    check_eq("ld_tc_gate", a_tc, 0);
    step();
    check_eq("ld_over_cnt_q", a_q, 4);
    check_eq("ld_no_wrap", a_wrap, 0);
    a_ld = 1'b0;
    step();
    check_eq("cnt_after_ld", a_q, 5);

    // Reset mid-count with everything else asserted.
    a_rst = 1'b1; a_ld = 1'b1; a_clr = 1'b1;
    #1;
    check_eq("rst_mid_tc", a_tc, 0);
    step();
    check_eq("rst_mid_q", a_q, 0);
    a_rst = 1'b0; a_ld = 1'b0; a_clr = 1'b0; a_en = 1'b0;

    // Full-range MODULUS=16.
    b_en = 1'b1; b_up = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check_eq("b_q15", b_q, 15);
    check_eq("b_tc15", b_tc, 1);
    step();
    check_eq("b_q0", b_q, 0);
    check_eq("b_wrap", b_wrap, 1);
    b_up = 1'b0;
    #1;
    check_eq("b_tc_dn", b_tc, 1);
    step();
    check_eq("b_dn15", b_q, 15);
    b_en = 1'b0;

    // WIDTH=1, MODULUS=2: toggle, wrap every other cycle.
    c_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check_eq("c_q", c_q, i % 2);
      check_eq("c_wrap", c_wrap, (i % 2 == 0) ? 1 : 0);
    end
`ifdef MODN_CNT_OVF_STICKY_EN
    check_eq("c_ovf", c_ovf, 1);
`endif
    c_en = 1'b0;

    // Cascade: 100 enabled cycles.
    d_en = 1'b1;
    wrap_cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (d1_wrap) wrap_cnt++;
      if (i == 57) begin
        check_eq("casc_d0_57", d0_q, 7);
        check_eq("casc_d1_57", d1_q, 5);
      end
    end
    check_eq("casc_d0_q", d0_q, 0);
    check_eq("casc_d1_q", d1_q, 0);
    check_eq("casc_d1_wraps", wrap_cnt, 1);
    d_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
